cache_l2_responder: RTL and testbench

//  L2-side responder for the cache_controller L2 handshake (read_l2/write_l2 -> l2_ack).

---
 rtl/cache_l2_pkg.sv | 10 +
 rtl/cache_l2_lat_lfsr.sv | 26 ++
 rtl/cache_l2_responder.sv | 134 +++++++++++++
 tb/tb_cache_l2_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_l2_pkg.sv
// Shared types and constants for the L2 responder and its optional random-latency source.
package cache_l2_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACK, RELEASE} l2_state_e;
  typedef enum logic {OP_RD, OP_WR} l2_op_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shift Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          LAT_MAX   = 15;
endpackage

// File: rtl/cache_l2_lat_lfsr.sv
// Per-transaction latency source: 16-bit Galois LFSR, lat = 1 + (lfsr[3:0] % LAT).
// Used only when L2_RAND_LAT_EN is defined; advances once per step pulse.
module cache_l2_lat_lfsr
  import cache_l2_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [3:0] lat
);
  logic [15:0] lfsr_q, lfsr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (step) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  assign lat = 4'(1 + (int'(lfsr_q[3:0]) % LAT));
endmodule

// File: rtl/cache_l2_responder.sv
// L2-side responder: serves line fills / write-backs from a local store after a programmable latency.
// Define L2_RAND_LAT_EN for per-transaction pseudo-random latency (1..LAT) instead of fixed LAT.
module cache_l2_responder
  import cache_l2_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4,
  parameter int IDX_W    = 8,
  parameter int LAT      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_l2,
  input  logic              write_l2,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata,
  output logic              l2_ack,
  output logic              busy,
  output logic              protocol_err
);
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFFSET_W) - 1);

  l2_state_e         state_q, state_d;
  l2_op_e            op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              mem_we;
  logic [3:0]        lat_sel;
  logic [IDX_W-1:0]  idx;
  logic              req_accept;

  logic [LINE_W-1:0] mem [DEPTH];

  assign idx        = addr_q[OFFSET_W +: IDX_W];
  assign req_accept = (state_q == IDLE) && (read_l2 || write_l2);

`ifdef L2_RAND_LAT_EN
  cache_l2_lat_lfsr #(.LAT(LAT)) u_lat (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (req_accept),
    .lat   (lat_sel)
  );
`else
  assign lat_sel = 4'(LAT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  // Store contents survive reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wdata_q;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    valid_d = valid_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_accept) begin
          op_d    = write_l2 ? OP_WR : OP_RD;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = lat_sel - 4'd1;
          state_d = WAIT;
          if (read_l2 && write_l2) err_d = 1'b1;
        end
      end
      WAIT: begin
        // Own request must stay up and the other must stay down until the ack.
        if (op_q == OP_RD) begin
          if (!read_l2 || write_l2) err_d = 1'b1;
        end else begin
          if (!write_l2 || read_l2) err_d = 1'b1;
        end
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ACK;
          if (op_q == OP_WR) begin
            mem_we       = 1'b1;
            valid_d[idx] = 1'b1;
          end else begin
            rdata_d = valid_q[idx] ? mem[idx] : {(LINE_W/ADDR_W){addr_q & ~OFF_MASK}};
          end
        end
      end
      ACK:     state_d = RELEASE;
      RELEASE: if (!read_l2 && !write_l2) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    l2_ack       = (state_q == ACK);
    busy         = (state_q == WAIT) || (state_q == ACK);
    rdata        = rdata_q;
    protocol_err = err_q;
  end
endmodule

// File: tb/tb_cache_l2_responder.sv
// Directed self-checking bench for cache_l2_responder (LAT=4) with immediate assertions.
module tb_cache_l2_responder;
  import cache_l2_pkg::*;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         read_l2 = 1'b0;
  logic         write_l2 = 1'b0;
  logic [31:0]  addr = '0;
  logic [127:0] wdata = '0;
  logic [127:0] rdata;
  logic         l2_ack;
  logic         busy;
  logic         protocol_err;

  int n_checks = 0;
  int n_fail   = 0;

  cache_l2_responder #(.LAT(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read_l2      (read_l2),
    .write_l2     (write_l2),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .l2_ack       (l2_ack),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request, measure edges from the accepting edge to the ack, then release it.
  task automatic transact(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [127:0] wd, input int hold, input string tag);
    int n;
    int acks;
    read_l2  = rd;
    write_l2 = wr;
    addr     = a;
    wdata    = wd;
    n = 0;
    do begin
      tick();
      n++;
    end while (!l2_ack && n < 30);
`ifdef L2_RAND_LAT_EN
    check({tag, "_lat_range"}, 128'((n - 1 >= 1) && (n - 1 <= LAT)), 128'(1));
`else
    check({tag, "_lat"}, 128'(n - 1), 128'(LAT));
`endif
    check({tag, "_busy_at_ack"}, 128'(busy), 128'(1));
    tick();
    check({tag, "_ack_width"}, 128'(l2_ack), 128'(0));
    if (hold > 0) begin
      acks = 0;
      repeat (hold) begin
        tick();
        acks += int'(l2_ack);
      end
      check({tag, "_no_reack"}, 128'(acks), 128'(0));
      check({tag, "_busy_hold"}, 128'(busy), 128'(0));
    end
    read_l2  = 1'b0;
    write_l2 = 1'b0;
    tick();
    check({tag, "_idle"}, 128'(dut.state_q), 128'(IDLE));
  endtask

  initial begin
    logic [127:0] d1;
    logic [127:0] d2;
    logic [127:0] d3;
    int n;
    int acks;
    d1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
    d2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    d3 = 128'hCAFE_F00D_A5A5_5A5A_0000_FFFF_1234_ABCD;

    // Reset state
    #12;
    check("rst_ack",  128'(l2_ack), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_rdata", rdata, 128'(0));
    check("rst_err",  128'(protocol_err), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // T1: fill pattern for a never-written line
    transact(1'b1, 1'b0, 32'h0000_0120, '0, 0, "t1");
    check("t1_rdata", rdata, 128'h00000120_00000120_00000120_00000120);
    check("t1_err", 128'(protocol_err), 128'(0));

    // T2: write-back, rdata untouched, read back through a different offset
    transact(1'b0, 1'b1, 32'h0000_0040, d1, 0, "t2w");
    check("t2_rdata_after_wr", rdata, 128'h00000120_00000120_00000120_00000120);
    transact(1'b1, 1'b0, 32'h0000_004C, '0, 0, "t2r");
    check("t2_rdata", rdata, d1);

    // T3: request held for 10 cycles after the ack
    transact(1'b1, 1'b0, 32'h0000_004C, '0, 10, "t3");
    check("t3_err", 128'(protocol_err), 128'(0));

    // Aliasing: index 4 reached from an address 256 lines higher
    transact(1'b0, 1'b1, 32'h0000_1040, d3, 0, "alias_w");
    transact(1'b1, 1'b0, 32'h0000_0048, '0, 0, "alias_r");
    check("alias_rdata", rdata, d3);

    // T4: simultaneous read and write -> write wins, sticky error
    transact(1'b1, 1'b1, 32'h0000_0080, d2, 0, "t4");
    check("t4_err", 128'(protocol_err), 128'(1));
    transact(1'b1, 1'b0, 32'h0000_0080, '0, 0, "t4r");
    check("t4_rdata", rdata, d2);
    check("t4_err_sticky", 128'(protocol_err), 128'(1));

    // T5: write a line, then reset two cycles into a read's WAIT
    transact(1'b0, 1'b1, 32'h0000_0200, d3, 0, "t5w");
    read_l2 = 1'b1;
    addr    = 32'h0000_0200;
    tick();
    tick();
    rst_n   = 1'b0;
    read_l2 = 1'b0;
    #1;
    check("t5_busy", 128'(busy), 128'(0));
    check("t5_ack", 128'(l2_ack), 128'(0));
    check("t5_rdata", rdata, 128'(0));
    check("t5_err", 128'(protocol_err), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (10) begin
      tick();
      acks += int'(l2_ack);
    end
    check("t5_no_ack", 128'(acks), 128'(0));
    transact(1'b1, 1'b0, 32'h0000_0200, '0, 0, "t5r");
    check("t5_fill", rdata, 128'h00000200_00000200_00000200_00000200);

    // Request dropped mid-WAIT still completes, flags error
    read_l2 = 1'b1;
    addr    = 32'h0000_0300;
    tick();
    tick();
    read_l2 = 1'b0;
    n = 2;
    while (!l2_ack && n < 30) begin
      tick();
      n++;
    end
`ifndef L2_RAND_LAT_EN
    check("drop_lat", 128'(n - 1), 128'(LAT));
`endif
    check("drop_ack", 128'(l2_ack), 128'(1));
    check("drop_rdata", rdata, 128'h00000300_00000300_00000300_00000300);
    check("drop_err", 128'(protocol_err), 128'(1));
    tick();
    tick();

`ifdef L2_RAND_LAT_EN
    // T6: random latency stays within 1..LAT across many reads
    acks = 0;
    for (int i = 0; i < 200; i++) begin
      read_l2 = 1'b1;
      addr    = 32'(i) << 4;
      n = 0;
      do begin
        tick();
        n++;
      end while (!l2_ack && n < 30);
      acks += int'(l2_ack);
      check("t6_lat", 128'((n - 1 >= 1) && (n - 1 <= LAT)), 128'(1));
      read_l2 = 1'b0;
      tick();
      tick();
    end
    check("t6_acks", 128'(acks), 128'(200));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
